serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial multi-bit adder controller. Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake, then feeds them LSB-first through one instance of the one-bit `adder` cell, one bit per clock. It returns the WIDTH-bit sum, carry-out and signed overflow over a second valid/ready handshake. It is the area-minimal alternative to the ripple and carry-lookahead adders, for datapaths where latency is cheap and gates are not.

## Interface

Parameters
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- valid_i  in  1  request; the operands are valid.
- ready_o  out  1  block can accept a request.
- a_i  in  WIDTH  operand A, unsigned or two's complement.
- b_i  in  WIDTH  operand B.
- carry_i  in  1  carry-in.
- valid_o  out  1  result is valid.
- ready_i  in  1  consumer accepts the result.
- result_o  out  WIDTH  (A + B + carry_i) mod 2^WIDTH.
- carry_o  out  1  carry-out of bit WIDTH-1.
- overflow_o  out  1  signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation

- FSM states: IDLE, CALC, DONE.
  - ready_o = (state == IDLE).
  - valid_o = (state == DONE).
  - Both are decoded from registered state only.
- IDLE
  - When valid_i & ready_o:
    - a_i and b_i load into shift registers sa and sb.
    - carry_i loads into carry register cr.
    - Bit counter cnt clears to 0.
    - result shift register clears to 0.
    - Next state is CALC.
  - Otherwise IDLE holds all registers.
- CALC
  - Each cycle, `adder` is driven with a_i=sa[0], b_i=sb[0], carry_i=cr.
  - sa and sb shift right by 1, filling with 0.
  - result shifts right by 1, with sum_o entering bit WIDTH-1.
  - cr <= carry_o.
  - cnt <= cnt+1.
  - On the cycle where cnt == WIDTH-1:
    - carry_o register <= adder carry_o.
    - overflow_o register <= cr XOR adder carry_o, where cr is the carry into the MSB.
    - Next state is DONE.
- DONE
  - result_o, carry_o and overflow_o are held stable.
  - When ready_i = 1, next state is IDLE. Outputs keep their values until the next accept.
- Input handling
  - valid_i, a_i, b_i and carry_i are ignored outside IDLE.
  - Operands only need to be stable in the accept cycle.
- Output visibility
  - result_o is the result shift register and is observable during CALC.
  - Its content is meaningful only while valid_o = 1.
- Counter
  - cnt width is $clog2(WIDTH).
  - It never wraps: the FSM leaves CALC at WIDTH-1.
- G_o/P_o
  - The cell's G_o and P_o outputs are left unconnected.

## Timing

- Reset (rst_i = 1 at an edge): after that edge:
  - state = IDLE, so ready_o = 1 and valid_o = 0.
  - result_o = 0, carry_o = 0, overflow_o = 0.
  - sa, sb, cr and cnt = 0.
- Reset wins over every other event, including an accept or a result handshake in the same cycle.
- Reset during CALC or DONE aborts the operation.
  - No valid_o is produced for that request.
  - The block is ready in the next cycle.
- Latency: request accepted at edge k, then valid_o = 1 from edge k+WIDTH+1.
  - Edge k+1 through k+WIDTH are the WIDTH CALC cycles.
- Result handshake: if valid_o & ready_i at edge m, then valid_o = 0 and ready_o = 1 after edge m.
  - The next request can be accepted at edge m+1.
  - Peak throughput is one operation per WIDTH+2 cycles.
- Backpressure: ready_i held low keeps DONE indefinitely, with all outputs unchanged.
- ready_i while not in DONE has no effect.
- valid_i asserted while busy is neither queued nor lost. It is sampled again once ready_o returns.

## Test plan

All scenarios use WIDTH=8, request at edge 0 and ready_i=1 unless stated.

- Basic add: a=0x0F, b=0x01, cin=0 -> valid_o at edge 9; result 0x10, carry 0, overflow 0; ready_o low for edges 1..9, high after the handshake.
- Unsigned carry and carry-in:
  - 0xFF+0x01, cin 0 -> 0x00, carry 1, overflow 0.
  - 0xFF+0x00, cin 1 -> 0x00, carry 1, overflow 0.
- Signed overflow:
  - 0x7F+0x01 -> 0x80, carry 0, overflow 1.
  - 0x80+0x80 -> 0x00, carry 1, overflow 1.
  - 0x80+0x7F -> 0xFF, carry 0, overflow 0.
- Backpressure and busy input:
  - Hold ready_i=0 for 5 cycles after valid_o rises -> result/flags stable and valid_o held.
  - valid_i pulsed with a=0x55 during CALC/DONE -> ignored.
  - Then release ready_i -> IDLE next cycle.
- Reset mid-operation: assert rst_i one cycle at the 4th CALC cycle -> all outputs 0, ready_o=1, valid_o never rises for that request; a following 0x12+0x34 returns 0x46.
- Randomised back-to-back: 1000 requests with random a, b and cin and random ready_i stalls -> each result equals the reference {carry, sum} = a+b+cin, overflow matches, one result per request, in order.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built around a single one-bit
// full-adder cell. Operands enter over a valid/ready request handshake, are
// summed LSB-first one bit per clock, and the sum, carry-out and signed
// overflow leave over a second valid/ready handshake.

// One-bit full adder cell with generate/propagate outputs.
module adder (
    input  logic a_i,
    input  logic b_i,
    input  logic carry_i,
    output logic sum_o,
    output logic carry_o,
    output logic G_o,
    output logic P_o
);

    // Classic generate/propagate formulation of a full adder.
    always_comb begin
        G_o     = a_i & b_i;
        P_o     = a_i ^ b_i;
        sum_o   = (a_i ^ b_i) ^ carry_i;
        carry_o = (a_i & b_i) | ((a_i ^ b_i) & carry_i);
    end

endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             overflow_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] sa_reg;
    logic [WIDTH-1:0] sb_reg;
    logic [WIDTH-1:0] result_reg;
    logic             cr_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             overflow_reg;

    logic             bit_sum;
    logic             bit_carry;

    // The single one-bit cell; its generate/propagate outputs have no use here.
    adder u_adder (
        .a_i     (sa_reg[0]),
        .b_i     (sb_reg[0]),
        .carry_i (cr_reg),
        .sum_o   (bit_sum),
        .carry_o (bit_carry),
        .G_o     (),
        .P_o     ()
    );

    // Handshake flags decode straight from the registered state.
    assign ready_o    = (state_reg == IDLE);
    assign valid_o    = (state_reg == DONE);
    assign result_o   = result_reg;
    assign carry_o    = carry_reg;
    assign overflow_o = overflow_reg;

    // Control FSM and serial datapath in one clocked process; reset wins over all.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            sa_reg       <= '0;
            sb_reg       <= '0;
            result_reg   <= '0;
            cr_reg       <= 1'b0;
            cnt_reg      <= '0;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (valid_i) begin
                        sa_reg     <= a_i;
                        sb_reg     <= b_i;
                        cr_reg     <= carry_i;
                        cnt_reg    <= '0;
                        result_reg <= '0;
                        state_reg  <= CALC;
                    end
                end
                CALC: begin
                    sa_reg     <= {1'b0, sa_reg[WIDTH-1:1]};
                    sb_reg     <= {1'b0, sb_reg[WIDTH-1:1]};
                    result_reg <= {bit_sum, result_reg[WIDTH-1:1]};
                    cr_reg     <= bit_carry;
                    if (cnt_reg == LAST_BIT) begin
                        // cr_reg holds the carry into the MSB on this cycle.
                        carry_reg    <= bit_carry;
                        overflow_reg <= cr_reg ^ bit_carry;
                        state_reg    <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomised checks for serial_adder at WIDTH=8.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [WIDTH-1:0] a_i = '0;
    logic [WIDTH-1:0] b_i = '0;
    logic             carry_i = 1'b0;
    logic             valid_o;
    logic             ready_i = 1'b0;
    logic [WIDTH-1:0] result_o;
    logic             carry_o;
    logic             overflow_o;

    int tests  = 0;
    int failed = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .carry_i    (carry_i),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .result_o   (result_o),
        .carry_o    (carry_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] res;
        logic       c;
        logic       ov;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issue one request, wait for the result, hold ready_i low for 'stall'
    // cycles once valid_o is up, then complete the handshake.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input int stall,
                          output logic [7:0] res, output logic c, output logic ov,
                          output int lat, output bit busy_ok, output bit post_ok);
        int g;
        g = 0;
        while (!ready_o && g < 100) begin
            @(negedge clk_i);
            g++;
        end
        if (!ready_o) check("ready_wait_timeout", 64'(ready_o), 64'd1);
        a_i     = a;
        b_i     = b;
        carry_i = cin;
        valid_i = 1'b1;
        ready_i = (stall == 0);
        @(negedge clk_i);
        valid_i = 1'b0;
        lat     = 0;
        busy_ok = 1'b1;
        while (!valid_o && lat < 100) begin
            if (ready_o) busy_ok = 1'b0;
            @(negedge clk_i);
            lat++;
        end
        if (ready_o) busy_ok = 1'b0;
        res = result_o;
        c   = carry_o;
        ov  = overflow_o;
        if (stall > 0) begin
            repeat (stall) @(negedge clk_i);
            ready_i = 1'b1;
        end
        @(negedge clk_i);
        post_ok = (valid_o == 1'b0) && (ready_o == 1'b1);
        ready_i = 1'b0;
    endtask

    initial begin
        logic [7:0] res;
        logic       c;
        logic       ov;
        int         lat;
        bit         busy_ok;
        bit         post_ok;
        logic [7:0] held_res;
        logic       held_c;
        logic       held_ov;
        bit         seen_valid;

        vecs[0]  = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5]  = '{8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[6]  = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[7]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[8]  = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};
        vecs[10] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        check("reset_ready", 64'(ready_o), 64'd1);
        check("reset_valid", 64'(valid_o), 64'd0);
        check("reset_result", 64'(result_o), 64'd0);
        check("reset_flags", 64'({carry_o, overflow_o}), 64'd0);

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, res, c, ov, lat, busy_ok, post_ok);
            $display("[TB] vec %0d: %h+%h+%0d -> %h c=%0d ov=%0d lat=%0d", i,
                     vecs[i].a, vecs[i].b, vecs[i].cin, res, c, ov, lat);
            check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].res));
            check($sformatf("vec%0d_carry", i), 64'(c), 64'(vecs[i].c));
            check($sformatf("vec%0d_overflow", i), 64'(ov), 64'(vecs[i].ov));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(WIDTH));
            check($sformatf("vec%0d_ready_low_busy", i), 64'(busy_ok), 64'd1);
            check($sformatf("vec%0d_idle_after_hs", i), 64'(post_ok), 64'd1);
        end

        // Backpressure with busy-time requests: 0x3C+0x0F = 0x4B
        a_i = 8'h3C; b_i = 8'h0F; carry_i = 1'b0; valid_i = 1'b1; ready_i = 1'b0;
        @(negedge clk_i);
        a_i = 8'h55; b_i = 8'h00;   // stays asserted through CALC, must be ignored
        lat = 0;
        while (!valid_o && lat < 100) begin
            @(negedge clk_i);
            lat++;
        end
        check("bp_latency", 64'(lat), 64'(WIDTH));
        held_res = result_o; held_c = carry_o; held_ov = overflow_o;
        check("bp_result", 64'(held_res), 64'h4B);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check($sformatf("bp_hold%0d", k),
                  64'({valid_o, ready_o, result_o, carry_o, overflow_o}),
                  64'({1'b1, 1'b0, 8'h4B, 1'b0, 1'b0}));
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
        check("bp_idle_after_release", 64'({valid_o, ready_o}), 64'b01);
        repeat (3) @(negedge clk_i);
        check("bp_busy_request_dropped", 64'({valid_o, ready_o, result_o}),
              64'({1'b0, 1'b1, 8'h4B}));
        $display("[TB] backpressure: 3C+0F -> %h held 5 cycles", held_res);

        // Reset in the 4th CALC cycle
        a_i = 8'hAB; b_i = 8'h11; carry_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("midrst_outputs", 64'({result_o, carry_o, overflow_o}), 64'd0);
        check("midrst_handshake", 64'({valid_o, ready_o}), 64'b01);
        seen_valid = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_i);
            if (valid_o) seen_valid = 1'b1;
        end
        check("midrst_no_valid", 64'(seen_valid), 64'd0);
        run_op(8'h12, 8'h34, 1'b0, 0, res, c, ov, lat, busy_ok, post_ok);
        check("midrst_next_result", 64'({c, ov, res}), 64'({1'b0, 1'b0, 8'h46}));
        $display("[TB] reset mid-op, then 12+34 -> %h", res);

        // Randomised back-to-back with random consumer stalls
        for (int n = 0; n < 1000; n++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            logic [8:0] full;
            logic       exp_ov;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            full   = 9'(ra) + 9'(rb) + 9'(rc);
            exp_ov = (ra[7] == rb[7]) && (full[7] != ra[7]);
            run_op(ra, rb, rc, int'($urandom_range(0, 3)), res, c, ov, lat, busy_ok, post_ok);
            $display("[TB] rnd %0d: %h+%h+%0d -> %h c=%0d ov=%0d", n, ra, rb, rc, res, c, ov);
            check($sformatf("rnd%0d", n),
                  64'({lat == WIDTH, post_ok, c, ov, res}),
                  64'({1'b1, 1'b1, full[8], exp_ov, full[7:0]}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
